bit_count_unit: RTL and testbench

- Parametrised multi-mode bit-counting engine: one FSM plus a shift/accumulate datapath. Successor to the fixed-function count-ones FSM/datapath pair.
- Counts ones, zeros, or trailing zeros of a WIDTH-bit operand using a serial shift-right datapath.
- go/done handshake supports back-to-back restart from DONE.
- Sits beside the existing arithmetic blocks; driven by a host controller.

---
 rtl/bit_count_unit_pkg.sv | 23 ++
 rtl/bit_count_unit_if.sv | 44 ++++
 rtl/bit_count_unit_datapath.sv | 102 ++++++++++
 rtl/bit_count_unit.sv | 82 ++++++++
 tb/tb_bit_count_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_count_unit_pkg.sv
// -----------------------------------------------------------------------------
// bit_count_pkg
// Shared types for the bit-counting unit.
//   mode_t  : operation select captured with the operand
//             (MODE_RSVD behaves exactly like MODE_ONES)
//   state_t : control FSM states
// -----------------------------------------------------------------------------
package bit_count_pkg;

   typedef enum logic [1:0] {
      MODE_ONES  = 2'd0,
      MODE_ZEROS = 2'd1,
      MODE_TZ    = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

endpackage : bit_count_pkg

// File: rtl/bit_count_unit_if.sv
// -----------------------------------------------------------------------------
// bit_count_unit_if
// Host-side handshake bundle of the bit-counting unit.
//   go      : start/restart request (host -> unit)
//   mode    : operation select, captured with the operand (host -> unit)
//   in_data : WIDTH-bit operand (host -> unit)
//   out     : CW-bit result, valid while done is high (unit -> host)
//   done    : unit holds a result (unit -> host)
//   busy    : unit is computing (unit -> host)
// Modports: master = host controller, slave = bit_count_unit.
// -----------------------------------------------------------------------------
interface bit_count_unit_if #(
   parameter int WIDTH = 32
);
   import bit_count_pkg::*;

   localparam int CW = $clog2(WIDTH + 1);

   logic             go;
   mode_t            mode;
   logic [WIDTH-1:0] in_data;
   logic [CW-1:0]    out;
   logic             done;
   logic             busy;

   modport master (
      output go,
      output mode,
      output in_data,
      input  out,
      input  done,
      input  busy
   );

   modport slave (
      input  go,
      input  mode,
      input  in_data,
      output out,
      output done,
      output busy
   );

endinterface : bit_count_unit_if

// File: rtl/bit_count_unit_datapath.sv
// -----------------------------------------------------------------------------
// bit_count_datapath
// Serial shift-right counting datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture in_data/mode, clear count and iteration counter
//   step       : one iteration (shift operand, bump iteration, accumulate)
//   latch      : copy the running count to the result register
//   in_data    : operand
//   mode       : operation select
//   term       : termination condition for the current registers
//   out        : result register
// -----------------------------------------------------------------------------
module bit_count_datapath
   import bit_count_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             latch,
   input  logic [WIDTH-1:0] in_data,
   input  mode_t            mode,
   output logic             term,
   output logic [CW-1:0]    out
);

   logic [WIDTH-1:0] n_q, n_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    iter_q, iter_d;
   mode_t            mode_q, mode_d;
   logic [CW-1:0]    out_q, out_d;

   logic             inc;
   logic             iter_full;

   // The iteration counter only ever reaches WIDTH, which bounds both the
   // ZEROS/TZ loops and the count itself, so no overflow handling is needed.
   assign iter_full = (iter_q == CW'(WIDTH));

   always_comb begin
      inc  = n_q[0];
      term = (n_q == '0);
      case (mode_q)
         MODE_ZEROS: begin
            inc  = ~n_q[0];
            term = iter_full;
         end
         MODE_TZ: begin
            inc  = 1'b1;
            term = iter_full | n_q[0];
         end
         default: begin
            // ONES and the reserved encoding share the same behaviour.
            inc  = n_q[0];
            term = (n_q == '0);
         end
      endcase
   end

   always_comb begin
      n_d     = n_q;
      count_d = count_q;
      iter_d  = iter_q;
      mode_d  = mode_q;
      out_d   = out_q;
      if (load) begin
         n_d     = in_data;
         mode_d  = mode;
         count_d = '0;
         iter_d  = '0;
      end else if (step) begin
         n_d     = n_q >> 1;
         iter_d  = iter_q + CW'(1);
         count_d = count_q + CW'(inc);
      end
      if (latch) begin
         out_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q     <= '0;
         count_q <= '0;
         iter_q  <= '0;
         mode_q  <= MODE_ONES;
         out_q   <= '0;
      end else begin
         n_q     <= n_d;
         count_q <= count_d;
         iter_q  <= iter_d;
         mode_q  <= mode_d;
         out_q   <= out_d;
      end
   end

   assign out = out_q;

endmodule : bit_count_datapath

// File: rtl/bit_count_unit.sv
// -----------------------------------------------------------------------------
// bit_count_unit
// Multi-mode bit-counting engine: counts ones, zeros or trailing zeros of a
// WIDTH-bit operand with a serial shift-right datapath.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards any computation in flight
//   bus   : bit_count_unit_if slave (go, mode, in_data -> out, done, busy)
// The interface instance must be built with the same WIDTH as this module.
// -----------------------------------------------------------------------------
module bit_count_unit
   import bit_count_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   bit_count_unit_if.slave  bus
);

   state_t state_q, state_d;
   logic   load;
   logic   step;
   logic   latch;
   logic   term;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      latch   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // DONE accepts go exactly like IDLE, so a host holding go high
            // relaunches immediately and sees one done cycle per result.
            if (bus.go) begin
               load    = 1'b1;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            // go is deliberately ignored here; only reset aborts.
            if (term) begin
               latch   = 1'b1;
               state_d = DONE;
            end else begin
               step = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Status flags come straight from the state register so they never
   // depend combinationally on host inputs.
   assign bus.done = (state_q == DONE);
   assign bus.busy = (state_q == COMPUTE);

   bit_count_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .latch   (latch),
      .in_data (bus.in_data),
      .mode    (bus.mode),
      .term    (term),
      .out     (bus.out)
   );

endmodule : bit_count_unit

// File: tb/tb_bit_count_unit.sv
// -----------------------------------------------------------------------------
// tb_bit_count_unit
// Directed bench for bit_count_unit: an 8-bit instance for the per-mode
// cases and a 32-bit instance for go-held-high back-to-back operation.
// Latency is counted as the number of clock edges from the edge that
// samples go up to and including the edge after which done is high
// (k + 2 for k iterations).
// -----------------------------------------------------------------------------
module tb_bit_count_unit;
   import bit_count_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   bit_count_unit_if #(.WIDTH(8))  bus8 ();
   bit_count_unit_if #(.WIDTH(32)) bus32 ();

   bit_count_unit #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8)
   );

   bit_count_unit #(.WIDTH(32)) dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one 8-bit operation and wait (bounded) for done.
   task automatic run8(input logic [7:0] data, input mode_t m,
                       output int cyc, output logic [3:0] res);
      bus8.go      = 1'b1;
      bus8.in_data = data;
      bus8.mode    = m;
      @(posedge clk); #1;
      bus8.go = 1'b0;
      cyc = 1;
      while (!bus8.done && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      res = bus8.out;
      $display("txn w8 mode=%0d in=%02h -> out=%0d latency=%0d", m, data, res, cyc);
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus8.go      = 1'b0;
      bus8.mode    = MODE_ONES;
      bus8.in_data = '0;
      bus32.go     = 1'b0;
      bus32.mode   = MODE_ONES;
      bus32.in_data = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (bus8.done !== 1'b0) begin n_fail++; $display("FAIL reset_done8: got %b expected 0", bus8.done); end
      n_checks++;
      if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", bus8.busy); end
      n_checks++;
      if (bus8.out !== 4'd0) begin n_fail++; $display("FAIL reset_out8: got %0d expected 0", bus8.out); end
      n_checks++;
      if (bus32.done !== 1'b0 || bus32.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags32: got done=%b busy=%b expected 0 0", bus32.done, bus32.busy);
      end
      n_checks++;
      if (bus32.out !== 6'd0) begin n_fail++; $display("FAIL reset_out32: got %0d expected 0", bus32.out); end
      $display("txn reset released");
   endtask

   task automatic test_ones();
      int cyc;
      logic [3:0] res;
      run8(8'b0010_1101, MODE_ONES, cyc, res);
      n_checks++;
      if (res !== 4'd4) begin n_fail++; $display("FAIL ones_2d_out: got %0d expected 4", res); end
      n_checks++;
      if (cyc != 8) begin n_fail++; $display("FAIL ones_2d_lat: got %0d expected 8", cyc); end
      n_checks++;
      if (bus8.busy !== 1'b0) begin n_fail++; $display("FAIL ones_2d_busy: got %b expected 0", bus8.busy); end
      run8(8'h00, MODE_ONES, cyc, res);
      n_checks++;
      if (res !== 4'd0) begin n_fail++; $display("FAIL ones_00_out: got %0d expected 0", res); end
      n_checks++;
      if (cyc != 2) begin n_fail++; $display("FAIL ones_00_lat: got %0d expected 2", cyc); end
      run8(8'h2D, MODE_RSVD, cyc, res);
      n_checks++;
      if (res !== 4'd4) begin n_fail++; $display("FAIL rsvd_2d_out: got %0d expected 4", res); end
      n_checks++;
      if (cyc != 8) begin n_fail++; $display("FAIL rsvd_2d_lat: got %0d expected 8", cyc); end
   endtask

   task automatic test_reset_mid_compute();
      int cyc;
      logic [3:0] res;
      run8(8'h2D, MODE_ONES, cyc, res);   // leaves out=4 so the reset clear is visible
      bus8.go      = 1'b1;
      bus8.in_data = 8'hFF;
      bus8.mode    = MODE_ONES;
      @(posedge clk); #1;
      bus8.go = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus8.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", bus8.busy); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
         n_fail++; $display("FAIL midrst_flags: got done=%b busy=%b expected 0 0", bus8.done, bus8.busy);
      end
      n_checks++;
      if (bus8.out !== 4'd0) begin n_fail++; $display("FAIL midrst_out: got %0d expected 0", bus8.out); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle%0d: got done=%b busy=%b expected 0 0", i, bus8.done, bus8.busy);
         end
      end
      $display("txn reset mid-compute");
   endtask

   task automatic test_zeros();
      int cyc;
      logic [3:0] res;
      run8(8'b0010_1101, MODE_ZEROS, cyc, res);
      n_checks++;
      if (res !== 4'd4) begin n_fail++; $display("FAIL zeros_2d_out: got %0d expected 4", res); end
      n_checks++;
      if (cyc != 10) begin n_fail++; $display("FAIL zeros_2d_lat: got %0d expected 10", cyc); end
      run8(8'hFF, MODE_ZEROS, cyc, res);
      n_checks++;
      if (res !== 4'd0) begin n_fail++; $display("FAIL zeros_ff_out: got %0d expected 0", res); end
      n_checks++;
      if (cyc != 10) begin n_fail++; $display("FAIL zeros_ff_lat: got %0d expected 10", cyc); end
   endtask

   task automatic test_tz();
      int cyc;
      logic [3:0] res;
      run8(8'b0101_1000, MODE_TZ, cyc, res);
      n_checks++;
      if (res !== 4'd3) begin n_fail++; $display("FAIL tz_58_out: got %0d expected 3", res); end
      n_checks++;
      if (cyc != 5) begin n_fail++; $display("FAIL tz_58_lat: got %0d expected 5", cyc); end
      run8(8'h00, MODE_TZ, cyc, res);
      n_checks++;
      if (res !== 4'd8) begin n_fail++; $display("FAIL tz_00_out: got %0d expected 8", res); end
      n_checks++;
      if (cyc != 10) begin n_fail++; $display("FAIL tz_00_lat: got %0d expected 10", cyc); end
      run8(8'h01, MODE_TZ, cyc, res);
      n_checks++;
      if (res !== 4'd0) begin n_fail++; $display("FAIL tz_01_out: got %0d expected 0", res); end
      n_checks++;
      if (cyc != 2) begin n_fail++; $display("FAIL tz_01_lat: got %0d expected 2", cyc); end
      run8(8'hFF, MODE_TZ, cyc, res);
      n_checks++;
      if (res !== 4'd0 || cyc != 2) begin
         n_fail++; $display("FAIL tz_ff: got out=%0d lat=%0d expected out=0 lat=2", res, cyc);
      end
   endtask

   task automatic test_restart();
      int cyc;
      logic [3:0] res;
      logic held_ok;
      run8(8'b0010_1111, MODE_ONES, cyc, res);   // 5 ones
      n_checks++;
      if (res !== 4'd5) begin n_fail++; $display("FAIL rs_first_out: got %0d expected 5", res); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (bus8.done !== 1'b1 || bus8.out !== 4'd5) begin
            n_fail++; $display("FAIL rs_hold%0d: got done=%b out=%0d expected 1 5", i, bus8.done, bus8.out);
         end
      end
      bus8.go      = 1'b1;
      bus8.in_data = 8'hF0;
      bus8.mode    = MODE_ZEROS;
      @(posedge clk); #1;
      bus8.go = 1'b0;
      cyc = 1;
      n_checks++;
      if (bus8.done !== 1'b0 || bus8.busy !== 1'b1) begin
         n_fail++; $display("FAIL rs_launch: got done=%b busy=%b expected 0 1", bus8.done, bus8.busy);
      end
      held_ok = 1'b1;
      while (!bus8.done && cyc < 100) begin
         if (bus8.out !== 4'd5) held_ok = 1'b0;
         if (cyc == 2) begin
            // go plus fresh operand while busy must be ignored
            bus8.go      = 1'b1;
            bus8.in_data = 8'hFF;
            bus8.mode    = MODE_ONES;
         end else begin
            bus8.go = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus8.go = 1'b0;
      $display("txn w8 restart zeros in=f0 -> out=%0d latency=%0d", bus8.out, cyc);
      n_checks++;
      if (held_ok !== 1'b1) begin n_fail++; $display("FAIL rs_out_held: got held=%b expected 1", held_ok); end
      n_checks++;
      if (bus8.out !== 4'd4) begin n_fail++; $display("FAIL rs_second_out: got %0d expected 4", bus8.out); end
      n_checks++;
      if (cyc != 10) begin n_fail++; $display("FAIL rs_second_lat: got %0d expected 10", cyc); end
      @(posedge clk); #1;
      n_checks++;
      if (bus8.done !== 1'b1 || bus8.out !== 4'd4) begin
         n_fail++; $display("FAIL rs_stay_done: got done=%b out=%0d expected 1 4", bus8.done, bus8.out);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ops  [3];
      mode_t       mds  [3];
      logic [5:0]  exps [3];
      int          lats [3];
      int          cyc;
      ops[0] = 32'hFFFF_FFFF; mds[0] = MODE_ONES; exps[0] = 6'd32; lats[0] = 34;
      ops[1] = 32'h8000_0000; mds[1] = MODE_TZ;   exps[1] = 6'd31; lats[1] = 33;
      ops[2] = 32'h0000_0003; mds[2] = MODE_RSVD; exps[2] = 6'd2;  lats[2] = 4;
      bus32.go = 1'b1;
      for (int t = 0; t < 3; t++) begin
         bus32.in_data = ops[t];
         bus32.mode    = mds[t];
         @(posedge clk); #1;
         cyc = 1;
         n_checks++;
         if (bus32.done !== 1'b0 || bus32.busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b%0d_launch: got done=%b busy=%b expected 0 1", t, bus32.done, bus32.busy);
         end
         while (!bus32.done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
         end
         if (t == 2) bus32.go = 1'b0;
         $display("txn w32 mode=%0d in=%08h -> out=%0d latency=%0d", mds[t], ops[t], bus32.out, cyc);
         n_checks++;
         if (bus32.out !== exps[t]) begin n_fail++; $display("FAIL b2b%0d_out: got %0d expected %0d", t, bus32.out, exps[t]); end
         n_checks++;
         if (cyc != lats[t]) begin n_fail++; $display("FAIL b2b%0d_lat: got %0d expected %0d", t, cyc, lats[t]); end
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus32.done !== 1'b1 || bus32.out !== 6'd2) begin
         n_fail++; $display("FAIL b2b_final_hold: got done=%b out=%0d expected 1 2", bus32.done, bus32.out);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_ones();
      test_reset_mid_compute();
      test_zeros();
      test_tz();
      test_restart();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_bit_count_unit
